uart_axis_frame: RTL and testbench
==================================

// Module: uart_axis_frame
// PURPOSE
// - Parametrised full-duplex UART with AXI-Stream data ports; successor to the fixed 8N1 uart core.
// - Adds configurable data width, parity, stop bits, RX error tagging and an overrun flag.
// - Sits between the fabric stream logic (loopback or PS bridge) and the rx/tx pins.
// - Runs in the 10 MHz PL clock domain.
// PARAMETERS
// - TICKS_PER_BIT  87  clk cycles per bit, >=4 (87 @ 10 MHz ~ 115200 baud)
// - DATA_WIDTH     8   data bits per frame, 5..9, sent LSB first
// - PARITY         0   0 = none, 1 = odd, 2 = even
// - STOP_BITS      1   TX stop bits, 1 or 2; RX checks only the first stop bit
// PORTS
// - clk                 in   1           system clock
// - rst_n               in   1           asynchronous active-low reset
// - rx                  in   1           serial input, asynchronous, idle high
// - tx                  out  1           serial output, idle high
// - s_axis_din_tdata    in   DATA_WIDTH  byte to transmit
// - s_axis_din_tvalid   in   1           TX data valid
// - s_axis_din_tready   out  1           TX ready (high only in TX_IDLE)
// - m_axis_dout_tdata   out  DATA_WIDTH  received data
// - m_axis_dout_tuser   out  2           {parity_err, frame_err} for this beat
// - m_axis_dout_tvalid  out  1           RX data valid
// - m_axis_dout_tready  in   1           RX sink ready
// - tx_busy             out  1           TX frame in progress
// - rx_busy             out  1           RX frame in progress
// - rx_overrun          out  1           1-cycle pulse: completed frame dropped
// BEHAVIOUR
// - Reset values: tx=1, s_axis_din_tready=1, m_axis_dout_tvalid=0, tdata=0, tuser=0,
//   tx_busy=0, rx_busy=0, rx_overrun=0; both rx sync flops=1.
// - Bit timer: $clog2(TICKS_PER_BIT)-bit counter, counts 0..TICKS_PER_BIT-1, then reloads.
// - TX FSM: TX_IDLE -> TX_START -> TX_DATA -> [TX_PAR] -> TX_STOP.
//   - Transfer occurs when tvalid & tready in TX_IDLE; data is latched and tready drops the next cycle.
//   - tx goes low on the cycle after the transfer. Each bit holds exactly TICKS_PER_BIT cycles.
//   - TX_PAR is skipped when PARITY=0.
//   - Parity bit: even = ^data, odd = ~^data.
//   - TX_STOP lasts STOP_BITS*TICKS_PER_BIT cycles; then TX_IDLE, and tready=1 that cycle.
//   - Latency: tready low for (1+DATA_WIDTH+(PARITY!=0)+STOP_BITS)*TICKS_PER_BIT cycles.
//   - tx_busy = !tready.
// - RX path: 2-flop synchroniser, then FSM RX_IDLE -> RX_START -> RX_DATA -> [RX_PAR] -> RX_STOP.
//   - RX_IDLE: a synced 1->0 edge starts the timer, which counts TICKS_PER_BIT/2 (integer divide).
//   - RX_START: line still 0 at mid-bit -> RX_DATA; line 1 -> RX_IDLE (glitch, no output).
//   - Subsequent samples are taken every TICKS_PER_BIT cycles, at each bit centre.
//   - RX_STOP samples at the stop centre: frame_err = (sample==0); parity_err = computed != received.
//     parity_err is always 0 when PARITY=0.
//   - At that stop sample the FSM returns to RX_IDLE immediately, so back-to-back frames are accepted.
//   - rx_busy is high in every state except RX_IDLE.
// - RX output register:
//   - A completed frame with tvalid=0: tdata/tuser load and tvalid=1 on the next cycle.
//   - tvalid drops the cycle after tvalid & tready.
//   - A frame completing while tvalid=1 and tready=0: the new frame is dropped, the held beat
//     is unchanged, and rx_overrun pulses for 1 cycle.
//   - tready=1 in the same cycle as completion: the held beat retires, the new one loads, no overrun.
//   - Frames with errors are still delivered, with tuser set.
// - TX and RX are fully independent; simultaneous activity is allowed.
// - rst_n low mid-frame: both FSMs abort immediately to the reset values; no partial beat is
//   emitted after release.
// - s_axis_din_tdata is ignored while tready=0; a stalled tvalid waits with no timeout.
// CONFIGURATION
// - UART_RX_MAJORITY_EN defined: each RX bit decision is the 2-of-3 majority of samples at
//   centre-1, centre, centre+1.
//   - This applies to the start-bit confirm too.
//   - Requires TICKS_PER_BIT>=4.
//   - Decision timing is the centre+1 cycle, i.e. 1 cycle later than without the macro.
// - Undefined: a single sample at the centre cycle; no extra logic.
// TESTING (TICKS_PER_BIT=8, DATA_WIDTH=8 unless noted)
// - TX 8N1, send 0xA5:
//   - tx = 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
//   - tready low 80 cycles, then high.
// - Loop tx->rx, PARITY=2, STOP_BITS=2, send 0x3C:
//   - dout=0x3C, tuser=00.
//   - tx parity bit = 0.
//   - tready low 96 cycles.
// - Inject an odd-parity frame with a wrong parity bit, then a frame with stop=0:
//   - Frame 1: tuser=10.
//   - Frame 2: tuser=01, data still delivered.
// - Hold m_axis_dout_tready=0, receive 0x11 then 0x22:
//   - dout stays 0x11.
//   - rx_overrun pulses exactly 1 cycle at the 0x22 stop centre.
// - 3-cycle low glitch on rx, and separately rst_n low mid-TX:
//   - Glitch: no beat, rx_busy returns to 0.
//   - Reset: tx=1 and tready=1 immediately.
// - UART_RX_MAJORITY_EN: single-cycle inverted spike at a data bit centre -> byte received correct.

Source files
------------

// File: rtl/uart_axis_frame.sv
// -----------------------------------------------------------------------------
// uart_axis_frame
//   Full-duplex UART with AXI-Stream data ports. The frame format is set by
//   parameters: data width, parity and TX stop bits. Received beats carry an
//   error tag in tuser. A frame that completes while the output register is
//   still held by the sink is dropped and reported on rx_overrun.
//
// Parameters
//   TICKS_PER_BIT  clk cycles per bit (>= 4)
//   DATA_WIDTH     data bits per frame, 5..9, sent LSB first
//   PARITY         0 = none, 1 = odd, 2 = even
//   STOP_BITS      TX stop bits, 1 or 2 (RX checks only the first stop bit)
//
// Build option
//   UART_RX_MAJORITY_EN  each RX bit decision (start confirm included) is the
//                        2-of-3 majority of the samples at centre-1, centre and
//                        centre+1. The decision is taken on the centre+1 cycle.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rx / tx             serial lines, both idle high
//   s_axis_din_*        TX stream in (tready high only while TX is idle)
//   m_axis_dout_*       RX stream out; tuser = {parity_err, frame_err}
//   tx_busy, rx_busy    frame in progress on each direction
//   rx_overrun          1-cycle pulse when a completed frame is dropped
// -----------------------------------------------------------------------------
module uart_axis_frame #(
   parameter int TICKS_PER_BIT = 87,
   parameter int DATA_WIDTH    = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx,
   output logic                  tx,
   input  logic [DATA_WIDTH-1:0] s_axis_din_tdata,
   input  logic                  s_axis_din_tvalid,
   output logic                  s_axis_din_tready,
   output logic [DATA_WIDTH-1:0] m_axis_dout_tdata,
   output logic [1:0]            m_axis_dout_tuser,
   output logic                  m_axis_dout_tvalid,
   input  logic                  m_axis_dout_tready,
   output logic                  tx_busy,
   output logic                  rx_busy,
   output logic                  rx_overrun
);

   localparam int              CNT_W      = $clog2(TICKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
   // Majority decision needs the centre+1 sample, so it lands one cycle later.
   localparam logic [CNT_W-1:0] START_SMP = CNT_W'(TICKS_PER_BIT / 2);
`else
   localparam logic [CNT_W-1:0] START_SMP = CNT_W'(TICKS_PER_BIT / 2 - 1);
`endif
   localparam logic [3:0]      LAST_DATA  = 4'(DATA_WIDTH - 1);
   localparam logic [3:0]      LAST_STOP  = 4'(STOP_BITS - 1);
   localparam bit              HAS_PARITY = (PARITY != 0);

   // Parity bit value that a correct frame carries for this data word.
   function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
      return (PARITY == 2) ? ^d : ~^d;
   endfunction

   // ---------------------------------------------------------------- TX ----
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

   tx_state_t             tx_state, tx_state_n;
   logic [CNT_W-1:0]      tx_cnt, tx_cnt_n;
   logic [3:0]            tx_idx, tx_idx_n;
   logic [DATA_WIDTH-1:0] tx_shreg, tx_shreg_n;
   logic                  tx_par, tx_par_n;
   logic                  tx_n;
   logic                  tx_tick;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      tx_state_n = tx_state;
      tx_idx_n   = tx_idx;
      tx_shreg_n = tx_shreg;
      tx_par_n   = tx_par;
      tx_tick    = (tx_cnt == CNT_LAST);
      tx_cnt_n   = (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;

      unique case (tx_state)
         TX_IDLE: if (s_axis_din_tvalid) begin
            tx_state_n = TX_START;
            tx_shreg_n = s_axis_din_tdata;
            tx_par_n   = parity_of(s_axis_din_tdata);
         end
         TX_START: if (tx_tick) begin
            tx_state_n = TX_DATA;
            tx_idx_n   = '0;
         end
         TX_DATA: if (tx_tick) begin
            tx_shreg_n = tx_shreg >> 1;
            if (tx_idx == LAST_DATA) begin
               tx_idx_n   = '0;
               tx_state_n = HAS_PARITY ? TX_PAR : TX_STOP;
            end else begin
               tx_idx_n = tx_idx + 1'b1;
            end
         end
         TX_PAR: if (tx_tick) begin
            tx_idx_n   = '0;
            tx_state_n = TX_STOP;
         end
         TX_STOP: if (tx_tick) begin
            if (tx_idx == LAST_STOP) tx_state_n = TX_IDLE;
            else                     tx_idx_n   = tx_idx + 1'b1;
         end
         default: tx_state_n = TX_IDLE;
      endcase

      // The line level is registered from the next state, so tx never glitches.
      unique case (tx_state_n)
         TX_START: tx_n = 1'b0;
         TX_DATA:  tx_n = tx_shreg_n[0];
         TX_PAR:   tx_n = tx_par_n;
         default:  tx_n = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values and simulation matches the synthesised flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shreg <= '0;
         tx_par   <= 1'b0;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_idx   <= tx_idx_n;
         tx_shreg <= tx_shreg_n;
         tx_par   <= tx_par_n;
         tx       <= tx_n;
      end
   end

   assign s_axis_din_tready = (tx_state == TX_IDLE);
   assign tx_busy           = (tx_state != TX_IDLE);

   // ---------------------------------------------------------------- RX ----
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

   logic rx_meta, rx_sync, rx_sync_d;
   logic rx_bit;
`ifdef UART_RX_MAJORITY_EN
   logic rx_sync_d2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_sync_d  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
         rx_sync_d2 <= 1'b1;
`endif
      end else begin
         rx_meta    <= rx;
         rx_sync    <= rx_meta;
         rx_sync_d  <= rx_sync;
`ifdef UART_RX_MAJORITY_EN
         rx_sync_d2 <= rx_sync_d;
`endif
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // On the decision cycle: rx_sync = centre+1, rx_sync_d = centre, rx_sync_d2 = centre-1.
   assign rx_bit = (rx_sync & rx_sync_d) | (rx_sync & rx_sync_d2) | (rx_sync_d & rx_sync_d2);
`else
   assign rx_bit = rx_sync;
`endif

   rx_state_t             rx_state, rx_state_n;
   logic [CNT_W-1:0]      rx_cnt, rx_cnt_n;
   logic [3:0]            rx_idx, rx_idx_n;
   logic [DATA_WIDTH-1:0] rx_shreg, rx_shreg_n;
   logic                  rx_par_bit, rx_par_bit_n;
   logic                  rx_tick, rx_done, rx_ferr, rx_perr;

   always_comb begin
      rx_state_n   = rx_state;
      rx_idx_n     = rx_idx;
      rx_shreg_n   = rx_shreg;
      rx_par_bit_n = rx_par_bit;
      rx_done      = 1'b0;
      rx_ferr      = 1'b0;
      rx_perr      = 1'b0;
      rx_tick      = (rx_cnt == CNT_LAST);
      rx_cnt_n     = (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;

      unique case (rx_state)
         RX_IDLE: if (rx_sync_d && !rx_sync) rx_state_n = RX_START;
         RX_START: if (rx_cnt == START_SMP) begin
            // Re-align the timer so later samples fall on bit centres.
            rx_cnt_n = '0;
            if (rx_bit) begin
               rx_state_n = RX_IDLE;
            end else begin
               rx_state_n = RX_DATA;
               rx_idx_n   = '0;
            end
         end
         RX_DATA: if (rx_tick) begin
            rx_shreg_n = {rx_bit, rx_shreg[DATA_WIDTH-1:1]};
            if (rx_idx == LAST_DATA) rx_state_n = HAS_PARITY ? RX_PAR : RX_STOP;
            else                     rx_idx_n   = rx_idx + 1'b1;
         end
         RX_PAR: if (rx_tick) begin
            rx_par_bit_n = rx_bit;
            rx_state_n   = RX_STOP;
         end
         RX_STOP: if (rx_tick) begin
            // Return to idle at the stop centre so a back-to-back start edge is caught.
            rx_state_n = RX_IDLE;
            rx_done    = 1'b1;
            rx_ferr    = !rx_bit;
            rx_perr    = HAS_PARITY && (rx_par_bit != parity_of(rx_shreg));
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         rx_idx     <= '0;
         rx_shreg   <= '0;
         rx_par_bit <= 1'b0;
      end else begin
         rx_state   <= rx_state_n;
         rx_cnt     <= rx_cnt_n;
         rx_idx     <= rx_idx_n;
         rx_shreg   <= rx_shreg_n;
         rx_par_bit <= rx_par_bit_n;
      end
   end

   assign rx_busy = (rx_state != RX_IDLE);

   // Output register: a held beat blocks new frames unless it retires this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_dout_tdata  <= '0;
         m_axis_dout_tuser  <= '0;
         m_axis_dout_tvalid <= 1'b0;
         rx_overrun         <= 1'b0;
      end else begin
         rx_overrun <= 1'b0;
         if (m_axis_dout_tvalid && m_axis_dout_tready) m_axis_dout_tvalid <= 1'b0;
         if (rx_done) begin
            if (!m_axis_dout_tvalid || m_axis_dout_tready) begin
               m_axis_dout_tdata  <= rx_shreg;
               m_axis_dout_tuser  <= {rx_perr, rx_ferr};
               m_axis_dout_tvalid <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_axis_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_axis_frame
//   Three instances at TICKS_PER_BIT=8, DATA_WIDTH=8:
//     u_n1  8N1, rx looped from its own tx or driven by the bit-banger
//     u_p   even parity, 2 stop bits, rx looped from its own tx
//     u_odd odd parity, 1 stop bit, rx driven by the bit-banger
//   Expected beats go into per-instance queues; monitors pop them on each
//   output handshake. TX line levels come from a frame list assembled from
//   the frame-format rules.
// -----------------------------------------------------------------------------
module tb_uart_axis_frame;

   localparam int T = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       tv;
   logic [7:0] td;
   int         sel;
   logic       bb_rx, n1_bb, odd_bb;
   logic       rdy_n1, rdy_p, rdy_odd;
   bit         rand_rdy;

   int n_checks = 0;
   int n_err    = 0;
   int ovr_cnt  = 0;

   logic [9:0] q_n1[$], q_p[$], q_odd[$];

   // DUT wires
   logic       tx_n1, trdy_n1, vld_n1, txb_n1, rxb_n1, ovr_n1, rx_n1;
   logic [7:0] dat_n1;
   logic [1:0] usr_n1;
   logic       tx_p, trdy_p, vld_p, txb_p, rxb_p, ovr_p;
   logic [7:0] dat_p;
   logic [1:0] usr_p;
   logic       tx_odd, trdy_odd, vld_odd, txb_odd, rxb_odd, ovr_odd, rx_odd;
   logic [7:0] dat_odd;
   logic [1:0] usr_odd;
   logic       tv_n1, tv_p, tx_obs, trdy_obs;

   assign tv_n1    = tv && (sel == 0);
   assign tv_p     = tv && (sel == 1);
   assign tx_obs   = (sel == 1) ? tx_p : tx_n1;
   assign trdy_obs = (sel == 1) ? trdy_p : trdy_n1;
   assign rx_n1    = n1_bb ? bb_rx : tx_n1;
   assign rx_odd   = odd_bb ? bb_rx : 1'b1;

   uart_axis_frame #(.TICKS_PER_BIT(T), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
      .clk(clk), .rst_n(rst_n), .rx(rx_n1), .tx(tx_n1),
      .s_axis_din_tdata(td), .s_axis_din_tvalid(tv_n1), .s_axis_din_tready(trdy_n1),
      .m_axis_dout_tdata(dat_n1), .m_axis_dout_tuser(usr_n1), .m_axis_dout_tvalid(vld_n1),
      .m_axis_dout_tready(rdy_n1), .tx_busy(txb_n1), .rx_busy(rxb_n1), .rx_overrun(ovr_n1));

   uart_axis_frame #(.TICKS_PER_BIT(T), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2)) u_p (
      .clk(clk), .rst_n(rst_n), .rx(tx_p), .tx(tx_p),
      .s_axis_din_tdata(td), .s_axis_din_tvalid(tv_p), .s_axis_din_tready(trdy_p),
      .m_axis_dout_tdata(dat_p), .m_axis_dout_tuser(usr_p), .m_axis_dout_tvalid(vld_p),
      .m_axis_dout_tready(rdy_p), .tx_busy(txb_p), .rx_busy(rxb_p), .rx_overrun(ovr_p));

   uart_axis_frame #(.TICKS_PER_BIT(T), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .rx(rx_odd), .tx(tx_odd),
      .s_axis_din_tdata(8'h00), .s_axis_din_tvalid(1'b0), .s_axis_din_tready(trdy_odd),
      .m_axis_dout_tdata(dat_odd), .m_axis_dout_tuser(usr_odd), .m_axis_dout_tvalid(vld_odd),
      .m_axis_dout_tready(rdy_odd), .tx_busy(txb_odd), .rx_busy(rxb_odd), .rx_overrun(ovr_odd));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Random sink backpressure
   always @(posedge clk) begin
      #1;
      if (rand_rdy) begin
         rdy_n1  = 1'($urandom_range(0, 1));
         rdy_p   = 1'($urandom_range(0, 1));
         rdy_odd = 1'($urandom_range(0, 1));
      end
   end

   always @(negedge clk) if (ovr_n1) ovr_cnt++;
   always @(negedge clk) if (ovr_p || ovr_odd) check("unexpected_overrun", 32'({ovr_p, ovr_odd}), 32'd0);

   // Scoreboard monitors
   always @(negedge clk) begin
      if (rst_n && vld_n1 && rdy_n1) begin
         if (q_n1.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL n1_unexpected_beat got=%0h required=no_beat", {usr_n1, dat_n1});
         end else begin
            check("n1_beat", 32'({usr_n1, dat_n1}), 32'(q_n1.pop_front()));
         end
      end
   end
   always @(negedge clk) begin
      if (rst_n && vld_p && rdy_p) begin
         if (q_p.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL p_unexpected_beat got=%0h required=no_beat", {usr_p, dat_p});
         end else begin
            check("p_beat", 32'({usr_p, dat_p}), 32'(q_p.pop_front()));
         end
      end
   end
   always @(negedge clk) begin
      if (rst_n && vld_odd && rdy_odd) begin
         if (q_odd.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL odd_unexpected_beat got=%0h required=no_beat", {usr_odd, dat_odd});
         end else begin
            check("odd_beat", 32'({usr_odd, dat_odd}), 32'(q_odd.pop_front()));
         end
      end
   end

   // Send one byte on instance s (0 = 8N1, 1 = 8E2) and check the line frame
   // and the tready-low duration. Looped frames are expected back clean.
   task automatic send_tx(input int s, input logic [7:0] b);
      logic frame[$];
      int   c;
      sel = s;
      frame.push_back(1'b0);
      for (int i = 0; i < 8; i++) frame.push_back(b[i]);
      if (s == 1) begin
         frame.push_back(^b);
         frame.push_back(1'b1);
         frame.push_back(1'b1);
      end else begin
         frame.push_back(1'b1);
      end
      c = 0;
      while (!trdy_obs && c < 1000) begin @(posedge clk); c++; end
      if (c >= 1000) check("tx_ready_timeout", 32'(trdy_obs), 32'd1);
      if (s == 1) q_p.push_back({2'b00, b}); else q_n1.push_back({2'b00, b});
      @(posedge clk); #1 tv = 1'b1; td = b;
      @(posedge clk); #1 tv = 1'b0; td = 8'($urandom);
      c = 0;
      @(negedge clk);
      while (!trdy_obs && c < frame.size() * T + 50) begin
         if (c < frame.size() * T) check($sformatf("tx_bit%0d", c / T), 32'(tx_obs), 32'(frame[c / T]));
         c++;
         @(negedge clk);
      end
      check("tx_tready_low_cycles", 32'(c), 32'(frame.size() * T));
      check("tx_idle_high", 32'(tx_obs), 32'd1);
   endtask

   // Drive one frame on bb_rx. spike >= 0 inverts one cycle at that bit's centre.
   task automatic bang(input logic [7:0] d, input bit has_par, input logic par,
                       input logic stop, input int spike);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (has_par) bits.push_back(par);
      bits.push_back(stop);
      for (int j = 0; j < bits.size(); j++) begin
         for (int k = 0; k < T; k++) begin
            @(posedge clk); #1 bb_rx = (j == spike && k == T / 2) ? ~bits[j] : bits[j];
         end
      end
      @(posedge clk); #1 bb_rx = 1'b1;
      repeat (2 * T) @(posedge clk);
   endtask

   // Odd-parity frame into u_odd with an expected tag built from the rules.
   task automatic bang_odd(input logic [7:0] d, input bit par_ok, input logic stop);
      logic good_par, par;
      good_par = ~^d;
      par      = par_ok ? good_par : ~good_par;
      q_odd.push_back({(par != good_par), ~stop, d});
      bang(d, 1'b1, par, stop, -1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int         c;
      rst_n = 1'b0; tv = 1'b0; td = 8'h00; sel = 0;
      bb_rx = 1'b1; n1_bb = 1'b0; odd_bb = 1'b0;
      rdy_n1 = 1'b0; rdy_p = 1'b0; rdy_odd = 1'b0; rand_rdy = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_tx", 32'(tx_n1), 32'd1);
      check("rst_tready", 32'(trdy_n1), 32'd1);
      check("rst_tvalid", 32'(vld_n1), 32'd0);
      check("rst_tdata_tuser", 32'({usr_n1, dat_n1}), 32'd0);
      check("rst_busy_ovr", 32'({txb_n1, rxb_n1, ovr_n1}), 32'd0);
      check("rst_other_inst", 32'({tx_p, trdy_p, tx_odd, trdy_odd, vld_p, vld_odd}), 32'b111100);
      rst_n = 1'b1;
      rand_rdy = 1'b1;
      repeat (3) @(posedge clk);

      // 8N1 loopback: fixed pattern, then random bytes
      send_tx(0, 8'hA5);
      for (int i = 0; i < 3; i++) send_tx(0, 8'($urandom));

      // 8E2 loopback: fixed pattern, then random bytes
      send_tx(1, 8'h3C);
      for (int i = 0; i < 3; i++) send_tx(1, 8'($urandom));

      // Odd parity injection: bad parity, then bad stop, then random frames
      odd_bb = 1'b1;
      bang_odd(8'h5A, 1'b0, 1'b1);
      bang_odd(8'h96, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) bang_odd(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`ifdef UART_RX_MAJORITY_EN
      // Single-cycle inverted spike at data bit 3 centre is voted out
      q_odd.push_back({2'b00, 8'hC3});
      bang(8'hC3, 1'b1, ~^8'hC3, 1'b1, 4);
`endif
      odd_bb = 1'b0;

      // 8N1 bit-banged frames, including one with a low stop bit
      n1_bb = 1'b1;
      b = 8'($urandom);
      q_n1.push_back({2'b00, b});
      bang(b, 1'b0, 1'b0, 1'b1, -1);
      b = 8'($urandom);
      q_n1.push_back({2'b01, b});
      bang(b, 1'b0, 1'b0, 1'b0, -1);
      repeat (10) @(posedge clk);

      // Overrun: sink stalled, 0x11 held, 0x22 dropped
      @(negedge clk);
      rand_rdy = 1'b0; rdy_n1 = 1'b0; rdy_p = 1'b1; rdy_odd = 1'b1;
      repeat (4) @(negedge clk);
      ovr_cnt = 0;
      q_n1.push_back({2'b00, 8'h11});
      bang(8'h11, 1'b0, 1'b0, 1'b1, -1);
      bang(8'h22, 1'b0, 1'b0, 1'b1, -1);
      @(negedge clk);
      check("ovr_held_data", 32'(dat_n1), 32'h11);
      check("ovr_held_valid", 32'(vld_n1), 32'd1);
      check("ovr_pulse_cycles", 32'(ovr_cnt), 32'd1);
      rdy_n1 = 1'b1;
      repeat (3) @(negedge clk);
      check("ovr_after_drain_valid", 32'(vld_n1), 32'd0);

      // Glitch: 3-cycle low pulse is rejected at the start-bit centre
      @(posedge clk); #1 bb_rx = 1'b0;
      repeat (3) @(posedge clk);
      #1 bb_rx = 1'b1;
      check("glitch_rx_busy_start", 32'(rxb_n1), 32'd1);
      repeat (20) @(posedge clk);
      #1;
      check("glitch_rx_busy_end", 32'(rxb_n1), 32'd0);
      check("glitch_no_beat", 32'(vld_n1), 32'd0);

      // Reset mid-frame on a looped 8N1 transmission
      n1_bb = 1'b0; sel = 0;
      @(posedge clk); #1 tv = 1'b1; td = 8'h00;
      @(posedge clk); #1 tv = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("pre_rst_busy", 32'({txb_n1, rxb_n1}), 32'b11);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx", 32'(tx_n1), 32'd1);
      check("mid_rst_tready", 32'(trdy_n1), 32'd1);
      check("mid_rst_rx_busy", 32'(rxb_n1), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      c = 0;
      repeat (120) begin
         @(negedge clk);
         if (vld_n1) c++;
      end
      check("post_rst_no_beat_cycles", 32'(c), 32'd0);

      // All expected beats delivered
      check("q_n1_empty", 32'(q_n1.size()), 32'd0);
      check("q_p_empty", 32'(q_p.size()), 32'd0);
      check("q_odd_empty", 32'(q_odd.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
